// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch stage: valid/ready request side,
// fixed-latency lookup pipeline, credit-limited response FIFO, flush and backdoor load.
module imem_fetch_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int CREDITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic [31:0]              rsp_addr,
    output logic                     rsp_err,
    input  logic                     flush,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);

    localparam int          IW  = $clog2(DEPTH);
    localparam int          PW  = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam int          CW  = $clog2(CREDITS + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   mem_q [DEPTH];
    logic          accept;
    logic          pop;
    logic          push;
    logic [31:0]   push_instr;
    logic [31:0]   push_addr;
    logic          push_err;
    logic [CW-1:0] credit_q, credit_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] lk_idx;
    logic          lk_err;
    logic [31:0]   lk_instr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(CREDITS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Nonblocking write gives read-before-write for a same-edge fetch.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Ready depends only on the registered credit count, never on req_valid/rsp_ready.
    assign req_ready = ~reset & (credit_q < CW'(CREDITS));
    assign accept    = req_valid & req_ready;

    // Stage 0: lookup in the acceptance cycle
    always_comb begin
        lk_idx   = req_addr[IW+1:2];
        lk_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:IW+2] != '0);
        lk_instr = lk_err ? NOP : mem_q[lk_idx];
    end

    // Stages 1..LATENCY-1: shift pipeline feeding the FIFO
    if (LATENCY > 1) begin : g_pipe
        localparam int NS = LATENCY - 1;
        logic [NS-1:0] vld_q;
        logic [NS-1:0] err_q;
        logic [31:0]   instr_q [NS];
        logic [31:0]   addr_q  [NS];

        // A request accepted in the flush cycle belongs to the new path and survives.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int i = 1; i < NS; i++) begin
                    vld_q[i] <= vld_q[i-1] & ~flush;
                end
            end
        end

        always_ff @(posedge clk) begin
            instr_q[0] <= lk_instr;
            addr_q[0]  <= req_addr;
            err_q[0]   <= lk_err;
            for (int i = 1; i < NS; i++) begin
                instr_q[i] <= instr_q[i-1];
                addr_q[i]  <= addr_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end

        assign push       = vld_q[NS-1] & ~flush;
        assign push_instr = instr_q[NS-1];
        assign push_addr  = addr_q[NS-1];
        assign push_err   = err_q[NS-1];
    end else begin : g_nopipe
        assign push       = accept;
        assign push_instr = lk_instr;
        assign push_addr  = req_addr;
        assign push_err   = lk_err;
    end

    // Response FIFO: head drives the outputs
    logic [31:0]        f_instr_q [CREDITS];
    logic [31:0]        f_addr_q  [CREDITS];
    logic [CREDITS-1:0] f_err_q;

    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_instr = rsp_valid ? f_instr_q[rptr_q] : '0;
    assign rsp_addr  = rsp_valid ? f_addr_q[rptr_q]  : '0;
    assign rsp_err   = rsp_valid & f_err_q[rptr_q];

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        credit_d = credit_q;
        if (flush) begin
            // Empty the FIFO by snapping the read pointer onto the write pointer.
            rptr_d   = wptr_q;
            count_d  = '0;
            credit_d = accept ? CW'(1) : '0;
        end else begin
            if (pop) begin
                rptr_d = ptr_inc(rptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case ({accept, pop})
                2'b10:   credit_d = credit_q + CW'(1);
                2'b01:   credit_d = credit_q - CW'(1);
                default: credit_d = credit_q;
            endcase
        end
        if (push) begin
            wptr_d = ptr_inc(wptr_q);
            if (flush) begin
                count_d = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            credit_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_instr_q[wptr_q] <= push_instr;
            f_addr_q[wptr_q]  <= push_addr;
            f_err_q[wptr_q]   <= push_err;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !flush && !pop && count_q == CW'(CREDITS)))
                else $error("imem_fetch_responder: push into full response FIFO");
        end
    end
`endif

endmodule
